// File: rtl/sk6812_frame_sched.sv
// SK6812 frame scheduler: reads NUM_LED pixels from RAM, streams them to the bit
// encoder over valid/ready, waits for the line to go idle, then holds the latch gap.
module sk6812_frame_sched #(
    parameter int NUM_LED     = 8,
    parameter int ADDR_W      = 3,
    parameter int PIX_W       = 32,
    parameter int RST_CYC     = 4000,
    parameter int REFRESH_CYC = 50000
) (
    input  logic              sys_clk,
    input  logic              sys_nrst,
    input  logic              start,
    input  logic              auto_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pix_data,
    input  logic              pix_ready,
    input  logic              enc_idle,
    output logic              busy,
    output logic              frame_done
);

    localparam int GAP_W = $clog2(RST_CYC + 1);
    localparam int REF_W = $clog2(REFRESH_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LED - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(RST_CYC - 1);
    localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REFRESH_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SEND,
        ST_DRAIN,
        ST_LATCH
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [GAP_W-1:0]  gap_reg;
    logic [REF_W-1:0]  ref_reg;
    logic              ref_hit;
    logic              trigger;

    // The frame_done cycle is already IDLE, but a request landing there is dropped.
    assign ref_hit = auto_en && (ref_reg == REF_LAST);
    assign trigger = (state_reg == ST_IDLE) && !frame_done && (start || ref_hit);

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= '0;
            gap_reg    <= '0;
            ref_reg    <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rd_en      <= 1'b0;
            frame_done <= 1'b0;

            // Free-running period counter; wraps even when the slot is missed mid-frame.
            if (!auto_en || trigger || (ref_reg == REF_LAST))
                ref_reg <= '0;
            else
                ref_reg <= ref_reg + 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (trigger) begin
                        rd_en     <= 1'b1;
                        rd_addr   <= idx_reg;
                        busy      <= 1'b1;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: state_reg <= ST_WAIT;
                ST_WAIT: begin
                    pix_data  <= rd_data;
                    pix_valid <= 1'b1;
                    state_reg <= ST_SEND;
                end
                ST_SEND: begin
                    if (pix_valid && pix_ready) begin
                        pix_valid <= 1'b0;
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            rd_addr   <= idx_reg + 1'b1;
                            rd_en     <= 1'b1;
                            state_reg <= ST_FETCH;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (enc_idle) begin
                        gap_reg   <= '0;
                        state_reg <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (gap_reg == GAP_LAST) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        idx_reg    <= '0;
                        state_reg  <= ST_IDLE;
                    end else begin
                        gap_reg <= gap_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sk6812_frame_sched.sv
// Directed bench for sk6812_frame_sched: a 4-LED instance and a 1-LED instance,
// pixel words checked against a scoreboard queue filled when each frame is requested.
module tb_sk6812_frame_sched;

    localparam int NL = 4;
    localparam int RC = 20;
    localparam int FC = 200;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        sys_nrst, start, auto_en, pix_ready, enc_idle;
    logic        rd_en, pix_valid, busy, frame_done;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data, pix_data;

    logic        start1, auto_en1, pix_ready1, enc_idle1;
    logic        rd_en1, pix_valid1, busy1, frame_done1;
    logic [2:0]  rd_addr1;
    logic [31:0] rd_data1, pix_data1;

    sk6812_frame_sched #(.NUM_LED(NL), .ADDR_W(3), .PIX_W(32), .RST_CYC(RC), .REFRESH_CYC(FC)) dut (
        .sys_clk(clk), .sys_nrst(sys_nrst), .start(start), .auto_en(auto_en),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .enc_idle(enc_idle), .busy(busy), .frame_done(frame_done)
    );

    sk6812_frame_sched #(.NUM_LED(1), .ADDR_W(3), .PIX_W(32), .RST_CYC(RC), .REFRESH_CYC(FC)) dut1 (
        .sys_clk(clk), .sys_nrst(sys_nrst), .start(start1), .auto_en(auto_en1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .pix_valid(pix_valid1), .pix_data(pix_data1), .pix_ready(pix_ready1),
        .enc_idle(enc_idle1), .busy(busy1), .frame_done(frame_done1)
    );

    logic [31:0] ram  [8];
    logic [31:0] ram1 [8];
    logic [31:0] pix_tab [4];

    always @(posedge clk) begin
        if (rd_en)  rd_data  <= ram[rd_addr];
        if (rd_en1) rd_data1 <= ram1[rd_addr1];
    end

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int xfer0 = 0, rden0 = 0, fd0 = 0, exp_addr = 0;
    int xfer1 = 0, rden1 = 0, fd1 = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < NL; i++) q0.push_back(pix_tab[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int f;
        int k;
        f = fd0;
        k = 0;
        while (fd0 == f && k < 300) begin
            tick();
            k++;
        end
        check(tag, fd0, f + 1);
    endtask

    // Monitor: handshakes and read strobes sampled on the falling edge.
    always @(negedge clk) begin
        if (!sys_nrst) begin
            exp_addr = 0;
        end else begin
            if (rd_en) begin
                check("rd_addr_order", rd_addr, exp_addr);
                exp_addr = (exp_addr + 1) % NL;
                rden0++;
            end
            if (pix_valid && pix_ready) begin
                if (q0.size() == 0) check("xfer_unexpected", 1, 0);
                else check("pix_data", pix_data, q0.pop_front());
                xfer0++;
            end
            if (frame_done) fd0++;
            if (rd_en1) rden1++;
            if (pix_valid1 && pix_ready1) begin
                if (q1.size() == 0) check("xfer1_unexpected", 1, 0);
                else check("pix_data1", pix_data1, q1.pop_front());
                xfer1++;
            end
            if (frame_done1) fd1++;
        end
    end

    initial begin
        int r, f, n, cyc, found;
        int t [3];
        logic prev_busy;
        logic [2:0] addr_or;

        for (int i = 0; i < 8; i++) begin
            ram[i]  = 32'h0;
            ram1[i] = 32'h0;
        end
        for (int i = 0; i < 4; i++) begin
            pix_tab[i] = 32'hA0C0_0000 | (32'(i) << 4) | 32'(i + 1);
            ram[i]     = pix_tab[i];
        end
        ram1[0] = 32'h5A5A_1234;

        sys_nrst = 1'b0; start = 1'b0; auto_en = 1'b0; pix_ready = 1'b1; enc_idle = 1'b1;
        start1 = 1'b0; auto_en1 = 1'b0; pix_ready1 = 1'b1; enc_idle1 = 1'b1;
        repeat (3) tick();
        check("reset_outputs", {rd_en, rd_addr, pix_valid, pix_data, busy, frame_done}, 64'h0);
        sys_nrst = 1'b1;
        tick();
        check("idle_outputs", {rd_en, rd_addr, pix_valid, pix_data, busy, frame_done}, 64'h0);

        // 1: basic frame, encoder goes idle 5 cycles after the last transfer
        enc_idle = 1'b0;
        push_frame();
        r = rden0;
        pulse_start();
        check("t1_rd_en_latency", rd_en, 1);
        check("t1_busy_set", busy, 1);
        tick();
        check("t1_valid_not_yet", pix_valid, 0);
        tick();
        check("t1_valid_latency", pix_valid, 1);
        n = 0;
        while (xfer0 < 4 && n < 100) begin
            tick();
            n++;
        end
        check("t1_xfers", xfer0, 4);
        repeat (5) tick();
        check("t1_drain_busy", {busy, frame_done}, 2'b10);
        enc_idle = 1'b1;
        n = 0;
        prev_busy = 1'b0;
        while (!frame_done && n < 100) begin
            prev_busy = busy;
            tick();
            n++;
        end
        check("t1_latch_gap", n, RC + 1);
        check("t1_busy_drop", busy, 0);
        check("t1_busy_before_done", prev_busy, 1);
        check("t1_rd_pulses", rden0 - r, 4);
        tick();
        check("t1_done_one_cycle", frame_done, 0);

        // 2: backpressure on pixel 1
        push_frame();
        r = xfer0;
        pulse_start();
        n = 0;
        while (xfer0 < r + 1 && n < 50) begin
            tick();
            n++;
        end
        check("t2_first_xfer", xfer0, r + 1);
        pix_ready = 1'b0;
        n = 0;
        while (!pix_valid && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_valid", pix_valid, 1);
            check("t2_hold_data", pix_data, pix_tab[1]);
            check("t2_no_rd_en", rd_en, 0);
            check("t2_rd_addr", rd_addr, 1);
            tick();
        end
        pix_ready = 1'b1;
        tick();
        check("t2_xfer_on_ready", {pix_valid, 32'(xfer0)}, {1'b0, 32'(r + 2)});
        wait_done("t2_frame_done");

        // 3: repeated start requests during a frame are dropped
        push_frame();
        f = fd0;
        for (int k = 0; k < 300 && fd0 == f; k++) begin
            start = (k % 5 == 0);
            tick();
        end
        start = 1'b0;
        check("t3_one_done", fd0, f + 1);
        repeat (60) tick();
        check("t3_no_requeue", fd0, f + 1);
        check("t3_idle", busy, 0);
        check("t3_queue_empty", q0.size(), 0);

        // 4: auto refresh
        push_frame(); push_frame(); push_frame();
        r = rden0;
        auto_en = 1'b1;
        cyc = 0;
        found = 0;
        while (found < 3 && cyc < 1000) begin
            tick();
            cyc++;
            if (rd_en && rd_addr == 3'd0) begin
                t[found] = cyc;
                found++;
            end
        end
        check("t4_starts", found, 3);
        check("t4_first_start", t[0], FC);
        check("t4_period1", t[1] - t[0], FC);
        check("t4_period2", t[2] - t[1], FC);
        auto_en = 1'b0;
        wait_done("t4_frame_done");
        repeat (500) tick();
        check("t4_no_auto_start", rden0 - r, 12);
        check("t4_queue_empty", q0.size(), 0);

        // 5: asynchronous reset in SEND
        pix_ready = 1'b0;
        push_frame();
        pulse_start();
        n = 0;
        while (!pix_valid && n < 10) begin
            tick();
            n++;
        end
        check("t5_in_send", pix_valid, 1);
        sys_nrst = 1'b0;
        #1;
        check("t5_async_reset", {rd_en, rd_addr, pix_valid, pix_data, busy, frame_done}, 64'h0);
        q0.delete();
        tick();
        sys_nrst = 1'b1;
        pix_ready = 1'b1;
        tick();
        push_frame();
        pulse_start();
        check("t5_restart_addr0", {rd_en, rd_addr}, 4'b1000);
        wait_done("t5_frame_done");

        // 6: single-LED chain
        q1.push_back(ram1[0]);
        f = fd1;
        r = rden1;
        addr_or = 3'd0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (fd1 == f && n < 100) begin
            addr_or = addr_or | rd_addr1;
            tick();
            n++;
        end
        check("t6_frame_done", fd1, f + 1);
        check("t6_rd_pulses", rden1 - r, 1);
        check("t6_xfers", xfer1, 1);
        check("t6_rd_addr_zero", addr_or, 0);
        check("t6_idle", busy1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
